au_addsub_seq: RTL and testbench

- Multi-cycle digit-serial adder-subtractor with carry-in and carry-out.
- Processes a WIDTH-bit operand pair DIGIT bits per clock, LSB digit first, and propagates the carry between cycles in a register.
- Arithmetically identical to the combinational AU adder-subtractor: s/co equal the low WIDTH bits and bit WIDTH of a+b+ci (add) or a-b-ci (sub).
- Used where wide operands must meet timing with a narrow carry chain, at the cost of latency.

---
 rtl/au_seq_pkg.sv | 19 +
 rtl/au_addsub_digit.sv | 16 +
 rtl/au_addsub_seq.sv | 137 +++++++++++++
 tb/tb_au_addsub_seq.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/au_seq_pkg.sv
// Shared types and sizing helpers for the digit-serial arithmetic units.
package au_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } au_state_e;

  function automatic int au_ceil_div(input int x, input int y);
    return (x + y - 1) / y;
  endfunction

  // Digit counter must be able to represent NDIG itself.
  function automatic int au_cnt_width(input int ndig);
    return $clog2(ndig + 1);
  endfunction

endpackage

// File: rtl/au_addsub_digit.sv
// Combinational DIGIT-bit adder slice with carry in and carry out.
module au_addsub_digit #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             cin,
  output logic [DIGIT-1:0] sum,
  output logic             cout
);

  always_comb begin
    {cout, sum} = {1'b0, x} + {1'b0, y} + (DIGIT + 1)'(cin);
  end

endmodule

// File: rtl/au_addsub_seq.sv
// Digit-serial adder-subtractor: one DIGIT-bit slice per clock, LSB digit first,
// carry held in a register between digits.
module au_addsub_seq
  import au_seq_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  input  logic             add_sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             co
);

  localparam int NDIG = au_ceil_div(WIDTH, DIGIT);
  localparam int PW   = NDIG * DIGIT;
  localparam int CW   = au_cnt_width(NDIG);
  localparam int REM  = WIDTH % DIGIT;
  localparam logic [CW-1:0] LAST_IDX = CW'(NDIG - 1);

  if (WIDTH < 1 || DIGIT < 1 || DIGIT > WIDTH) begin : g_bad_params
    $fatal(1, "au_addsub_seq: illegal WIDTH=%0d / DIGIT=%0d", WIDTH, DIGIT);
  end

  au_state_e        state_q, state_d;
  logic [PW-1:0]    a_q, a_d;
  logic [PW-1:0]    b_q, b_d;
  logic             carry_q, carry_d;
  logic             sub_q, sub_d;
  logic [CW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             co_q, co_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] badj;
  logic [DIGIT-1:0] dsum;
  logic             dcout;
  logic             craw;

  au_addsub_digit #(.DIGIT(DIGIT)) u_digit (
    .x    (a_q[DIGIT-1:0]),
    .y    (b_q[DIGIT-1:0]),
    .cin  (carry_q),
    .sum  (dsum),
    .cout (dcout)
  );

  // With a partial last digit the carry out of bit WIDTH-1 lands inside the slice.
  if (REM == 0) begin : g_full_last
    assign craw = dcout;
  end else begin : g_part_last
    assign craw = dsum[REM];
  end

  assign badj = add_sub ? ~b : b;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    sub_d   = sub_q;
    idx_d   = idx_q;
    s_d     = s_q;
    co_d    = co_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = PW'(a);
          b_d     = PW'(badj);
          sub_d   = add_sub;
          carry_d = ci ^ add_sub;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        // Operand registers shift down so the active digit is always at bit 0.
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        carry_d = dcout;
        idx_d   = idx_q + CW'(1);
        for (int j = 0; j < WIDTH; j++) begin
          if (j / DIGIT == int'(idx_q)) s_d[j] = dsum[j % DIGIT];
        end
        if (idx_q == LAST_IDX) begin
          co_d    = craw ^ sub_q;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      sub_q   <= 1'b0;
      idx_q   <= '0;
      s_q     <= '0;
      co_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      sub_q   <= sub_d;
      idx_q   <= idx_d;
      s_q     <= s_d;
      co_q    <= co_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign s    = s_q;
  assign co   = co_q;

endmodule

// File: tb/tb_au_addsub_seq.sv
// Bench for au_addsub_seq: four parameterisations driven in parallel, checked
// against an arithmetic reference model, directed tables and corner sequences.
module tb_au_addsub_seq;

  localparam int NDUT = 4;
  localparam int W0 = 16, D0 = 4;
  localparam int W1 = 10, D1 = 4;
  localparam int W2 = 7,  D2 = 1;
  localparam int W3 = 12, D3 = 12;
  localparam int NRAND = 2000;

  logic clk = 1'b0;
  logic rst, start, ci, add_sub;
  logic [31:0] a_in, b_in;

  logic busy0, done0, co0; logic [W0-1:0] s0;
  logic busy1, done1, co1; logic [W1-1:0] s1;
  logic busy2, done2, co2; logic [W2-1:0] s2;
  logic busy3, done3, co3; logic [W3-1:0] s3;

  logic        busy_v [NDUT];
  logic        done_v [NDUT];
  logic        co_v   [NDUT];
  logic [31:0] s_v    [NDUT];
  logic [31:0] res_s  [NDUT];
  logic        res_co [NDUT];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  au_addsub_seq #(.WIDTH(W0), .DIGIT(D0)) u_dut0 (
    .clk(clk), .rst(rst), .start(start), .a(a_in[W0-1:0]), .b(b_in[W0-1:0]),
    .ci(ci), .add_sub(add_sub), .busy(busy0), .done(done0), .s(s0), .co(co0));
  au_addsub_seq #(.WIDTH(W1), .DIGIT(D1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start), .a(a_in[W1-1:0]), .b(b_in[W1-1:0]),
    .ci(ci), .add_sub(add_sub), .busy(busy1), .done(done1), .s(s1), .co(co1));
  au_addsub_seq #(.WIDTH(W2), .DIGIT(D2)) u_dut2 (
    .clk(clk), .rst(rst), .start(start), .a(a_in[W2-1:0]), .b(b_in[W2-1:0]),
    .ci(ci), .add_sub(add_sub), .busy(busy2), .done(done2), .s(s2), .co(co2));
  au_addsub_seq #(.WIDTH(W3), .DIGIT(D3)) u_dut3 (
    .clk(clk), .rst(rst), .start(start), .a(a_in[W3-1:0]), .b(b_in[W3-1:0]),
    .ci(ci), .add_sub(add_sub), .busy(busy3), .done(done3), .s(s3), .co(co3));

  assign busy_v[0] = busy0; assign done_v[0] = done0; assign co_v[0] = co0; assign s_v[0] = 32'(s0);
  assign busy_v[1] = busy1; assign done_v[1] = done1; assign co_v[1] = co1; assign s_v[1] = 32'(s1);
  assign busy_v[2] = busy2; assign done_v[2] = done2; assign co_v[2] = co2; assign s_v[2] = 32'(s2);
  assign busy_v[3] = busy3; assign done_v[3] = done3; assign co_v[3] = co3; assign s_v[3] = 32'(s3);

  function automatic int wid(input int k);
    case (k)
      0: return W0;
      1: return W1;
      2: return W2;
      default: return W3;
    endcase
  endfunction

  function automatic int dig(input int k);
    case (k)
      0: return D0;
      1: return D1;
      2: return D2;
      default: return D3;
    endcase
  endfunction

  // Cycle (counting the start-sampling cycle as 0) in which done is expected.
  function automatic int lat(input int k);
    return (wid(k) + dig(k) - 1) / dig(k) + 1;
  endfunction

  // Reference: plain integer a+b+ci or a-b-ci; co is bit WIDTH of the result.
  function automatic void model(input int w, input logic [31:0] a, input logic [31:0] b,
                                input bit c, input bit sub,
                                output logic [31:0] s, output logic co);
    longint m, av, bv, r;
    m  = (longint'(1) << w) - 1;
    av = longint'(a) & m;
    bv = longint'(b) & m;
    r  = sub ? (av - bv - longint'(c)) : (av + bv + longint'(c));
    s  = 32'(r & m);
    co = sub ? (r < 0) : ((r >> w) != 0);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One operation on all DUTs at once; checks busy/done timing and the result.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input bit c, input bit sub);
    logic [31:0] es;
    logic        eco;
    @(negedge clk);
    a_in = a; b_in = b; ci = c; add_sub = sub; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a_in = $urandom; b_in = $urandom; ci = 1'($urandom); add_sub = 1'($urandom);
    for (int n = 1; n <= 9; n++) begin
      for (int k = 0; k < NDUT; k++) begin
        chk($sformatf("busy_d%0d_c%0d", k, n), 32'(busy_v[k]), 32'(n <= lat(k) - 1));
        chk($sformatf("done_d%0d_c%0d", k, n), 32'(done_v[k]), 32'(n == lat(k)));
        if (n == lat(k)) begin
          model(wid(k), a, b, c, sub, es, eco);
          res_s[k]  = s_v[k];
          res_co[k] = co_v[k];
          chk($sformatf("s_d%0d", k), s_v[k], es);
          chk($sformatf("co_d%0d", k), 32'(co_v[k]), 32'(eco));
        end
      end
      @(posedge clk);
      #1;
    end
    $display("op a=%08h b=%08h ci=%0d sub=%0d | s0=%h co0=%0d s1=%h co1=%0d s2=%h co2=%0d s3=%h co3=%0d",
             a, b, c, sub, res_s[0], res_co[0], res_s[1], res_co[1],
             res_s[2], res_co[2], res_s[3], res_co[3]);
  endtask

  typedef struct {
    int          dut;
    logic [31:0] a;
    logic [31:0] b;
    bit          c;
    bit          sub;
    logic [31:0] es;
    logic        eco;
  } vec_t;

  vec_t tbl [7];

  initial begin
    logic [31:0] ra, rb;

    tbl[0] = '{0, 32'hFFFF, 32'h0001, 1'b0, 1'b0, 32'h0000, 1'b1};
    tbl[1] = '{0, 32'h0000, 32'h0001, 1'b0, 1'b1, 32'hFFFF, 1'b1};
    tbl[2] = '{0, 32'h1234, 32'h0234, 1'b1, 1'b1, 32'h0FFF, 1'b0};
    tbl[3] = '{1, 32'h03FF, 32'h0001, 1'b0, 1'b0, 32'h0000, 1'b1};
    tbl[4] = '{1, 32'h0005, 32'h0005, 1'b0, 1'b1, 32'h0000, 1'b0};
    tbl[5] = '{2, 32'h007F, 32'h0001, 1'b1, 1'b0, 32'h0001, 1'b1};
    tbl[6] = '{3, 32'h0800, 32'h0801, 1'b0, 1'b1, 32'h0FFF, 1'b1};

    rst = 1'b1; start = 1'b0; ci = 1'b0; add_sub = 1'b0; a_in = '0; b_in = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 0; k < NDUT; k++) begin
      chk($sformatf("rst_busy_d%0d", k), 32'(busy_v[k]), 32'd0);
      chk($sformatf("rst_done_d%0d", k), 32'(done_v[k]), 32'd0);
      chk($sformatf("rst_s_d%0d", k), s_v[k], 32'd0);
      chk($sformatf("rst_co_d%0d", k), 32'(co_v[k]), 32'd0);
    end
    $display("reset state checked");

    for (int i = 0; i < 7; i++) begin
      run_op(tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].sub);
      chk($sformatf("tbl%0d_s", i), res_s[tbl[i].dut], tbl[i].es);
      chk($sformatf("tbl%0d_co", i), 32'(res_co[tbl[i].dut]), 32'(tbl[i].eco));
    end

    // start during RUN (cycle 2) and in the DONE cycle (cycle 5) must be dropped
    @(negedge clk);
    a_in = 32'h1; b_in = 32'h1; ci = 1'b0; add_sub = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    for (int n = 1; n <= 8; n++) begin
      start = (n == 2 || n == 5);
      a_in  = (n == 2) ? 32'hFFFF : 32'h1;
      b_in  = (n == 2) ? 32'hFFFF : 32'h1;
      chk($sformatf("ign_busy_c%0d", n), 32'(busy_v[0]), 32'(n <= 4));
      chk($sformatf("ign_done_c%0d", n), 32'(done_v[0]), 32'(n == 5));
      if (n == 5) begin
        chk("ign_s", s_v[0], 32'h0002);
        chk("ign_co", 32'(co_v[0]), 32'd0);
      end
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    $display("ignore-start sequence: s0=%h co0=%0d", s_v[0], co_v[0]);

    // reset in cycle 2 aborts: everything cleared, no done afterwards
    @(negedge clk);
    a_in = 32'h1234; b_in = 32'h1111; ci = 1'b0; add_sub = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 0; k < NDUT; k++) begin
      chk($sformatf("abort_busy_d%0d", k), 32'(busy_v[k]), 32'd0);
      chk($sformatf("abort_s_d%0d", k), s_v[k], 32'd0);
      chk($sformatf("abort_co_d%0d", k), 32'(co_v[k]), 32'd0);
    end
    for (int n = 3; n <= 10; n++) begin
      for (int k = 0; k < NDUT; k++)
        chk($sformatf("abort_done_d%0d_c%0d", k, n), 32'(done_v[k]), 32'd0);
      @(posedge clk);
      #1;
    end
    $display("abort sequence checked");
    run_op(32'hABCD, 32'h1357, 1'b1, 1'b1);

    for (int i = 0; i < NRAND; i++) begin
      ra = (i % 7 == 0) ? 32'hFFFF_FFFF : $urandom;
      rb = (i % 11 == 0) ? 32'hFFFF_FFFF : ((i % 13 == 0) ? 32'd0 : $urandom);
      run_op(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
